// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline-control types used by the processor and its control unit.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  localparam logic [3:0] RESP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctrlState_t;

  function automatic logic isExc(input logic [2:0] stat);
    return (stat == SADR) || (stat == SINS) || (stat == SHLT);
  endfunction

endpackage

// File: rtl/y86_hazard_detect.sv
// Raw combinational hazard terms for the Y86-64 pipeline, before FSM state overrides.
module y86_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       lu,
  output logic       retHaz,
  output logic       mis,
  output logic       exc,
  output logic       fStall,
  output logic       dStall,
  output logic       dBubble,
  output logic       eBubble,
  output logic       wStall,
  output logic       setCc
);

  assign lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign retHaz = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mis    = (E_icode == IJXX) && !e_Cnd;
  assign exc    = isExc(m_stat) || isExc(W_stat);

  assign fStall  = lu | retHaz;
  assign dStall  = lu;
  // A load/use stall holds D, so a pending ret must not also bubble it.
  assign dBubble = mis | (retHaz & ~lu);
  assign eBubble = mis | lu;
  assign wStall  = isExc(W_stat);
  assign setCc   = (E_icode == IOPQ) && !exc;

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Y86-64 pipeline control: hazard overrides, run/drain/halt FSM and saturating perf counters.
module y86_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       cpu_stat,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  ctrlState_t state, nextState;
  logic lu, retHaz, mis, exc, fStall, dStall, dBubble, eBubble, wStall, setCc;
  logic wdHit, haltOnStat, haltOnWd, active;

  y86_hazard_detect uHaz (
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .lu(lu), .retHaz(retHaz), .mis(mis), .exc(exc),
    .fStall(fStall), .dStall(dStall), .dBubble(dBubble),
    .eBubble(eBubble), .wStall(wStall), .setCc(setCc)
  );

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign active = (state != HALTED);
  assign wdHit  = (MAX_CYCLES != 0) && (cycle_cnt == WD_LAST);
  assign halted = (state == HALTED);

  always_comb begin
    nextState  = state;
    haltOnStat = 1'b0;
    haltOnWd   = 1'b0;
    unique case (state)
      RUN, DRAIN: begin
        // W_stat exception outranks the watchdog; the watchdog outranks entering DRAIN.
        if (wStall) begin
          nextState  = HALTED;
          haltOnStat = 1'b1;
        end else if (wdHit) begin
          nextState = HALTED;
          haltOnWd  = 1'b1;
        end else if (state == RUN && isExc(m_stat)) begin
          nextState = DRAIN;
        end
      end
      HALTED:  nextState = HALTED;
      default: nextState = RUN;
    endcase
  end

  always_comb begin
    F_stall  = fStall;
    D_stall  = dStall;
    W_stall  = wStall;
    D_bubble = dBubble;
    E_bubble = eBubble;
    M_bubble = exc;
    set_cc   = setCc;
    if (rst) begin
      {F_stall, D_stall, W_stall} = 3'b000;
      {D_bubble, E_bubble, M_bubble} = 3'b111;
      set_cc = 1'b0;
    end else if (state == HALTED) begin
      {F_stall, D_stall, W_stall} = 3'b111;
      {D_bubble, E_bubble, M_bubble} = 3'b011;
      set_cc = 1'b0;
    end else if (state == DRAIN) begin
      M_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cpu_stat    <= SAOK;
      timeout     <= 1'b0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      lu_cnt      <= '0;
      mispred_cnt <= '0;
      ret_cnt     <= '0;
    end else begin
      state <= nextState;
      if (haltOnStat) cpu_stat <= W_stat;
      if (haltOnWd)   timeout  <= 1'b1;
      if (active) begin
        cycle_cnt   <= satInc(cycle_cnt, 1'b1);
        retired_cnt <= satInc(retired_cnt, (W_stat == SAOK) && (W_icode != INOP));
        lu_cnt      <= satInc(lu_cnt, lu);
        mispred_cnt <= satInc(mispred_cnt, mis);
        ret_cnt     <= satInc(ret_cnt, retHaz & ~lu);
      end
    end
  end

endmodule

// File: doc/y86_pipe_ctrl.md
Name: y86_pipe_ctrl

Overview:
Pipeline control unit for the five-stage Y86-64 pipeline: F, D, E, M and W registers plus the fetch, decode/writeBack, execute and data_memory stages.
- Combinationally detects load/use, ret and mispredicted-branch hazards and drives stall/bubble controls into the pipeline registers.
- Gates condition-code updates while an exception is downstream.
- Runs a run/drain/halt FSM that replaces the top-level `$finish` on non-AOK status.
- Keeps saturating performance counters for the testbench and debug.

Parameters:
- CNT_W, 32, width of every performance counter.
- MAX_CYCLES, 0, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- D_icode  in  4  icode held in the D register.
- d_srcA, d_srcB  in  4 each  source registers decoded in D.
- E_icode  in  4  icode held in the E register.
- E_dstM  in  4  memory destination register held in E.
- e_Cnd  in  1  branch/cmov condition computed in execute.
- M_icode  in  4  icode held in the M register.
- m_stat  in  3  status leaving the memory stage.
- W_stat  in  3  status held in the W register.
- W_icode  in  4  icode held in the W register.
- F_stall, D_stall, W_stall  out  1 each  hold the named register.
- D_bubble, E_bubble, M_bubble  out  1 each  load a nop/SAOK/RNONE bubble into the named register.
- set_cc  out  1  condition-code write enable for execute.
- halted  out  1  the FSM is in HALTED.
- cpu_stat  out  3  latched final status (SAOK, SADR, SINS or SHLT).
- timeout  out  1  the watchdog ended the run.
- cycle_cnt, retired_cnt, lu_cnt, mispred_cnt, ret_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset is synchronous, active-high; clock port is clk, reset port is rst.
- While rst=1:
  - D_bubble=E_bubble=M_bubble=1; all stalls 0; set_cc=0.
  - Next state is RUN; cpu_stat=SAOK; halted=0, timeout=0; all counters 0.
- Exceptional status is defined as any stat in {SADR, SINS, SHLT}.
- Hazard terms (combinational, active only in RUN and DRAIN):
  - lu = (E_icode ∈ {MRMOVQ, POPQ}) and E_dstM ≠ RNONE and E_dstM ∈ {d_srcA, d_srcB}.
  - ret = IRET ∈ {D_icode, E_icode, M_icode}.
  - mis = (E_icode == JXX) and !e_Cnd.
  - exc = m_stat exceptional or W_stat exceptional.
- Control equations:
  - F_stall = lu | ret.
  - D_stall = lu.
  - D_bubble = mis | (ret & !lu). Load/use wins over ret, so D is held, not bubbled.
  - E_bubble = mis | lu.
  - M_bubble = exc.
  - W_stall = W_stat exceptional.
  - set_cc = (E_icode == OPQ) & !exc.
- mis together with ret (ret in D, jxx in E): D_bubble=1, E_bubble=1, F_stall=1.
- FSM states:
  - RUN: if m_stat exceptional and W_stat is not, go to DRAIN. If W_stat is exceptional, go to HALTED and latch cpu_stat=W_stat. If MAX_CYCLES≠0 and cycle_cnt == MAX_CYCLES−1, go to HALTED with timeout=1 and cpu_stat kept at SAOK. W_stat exception takes priority over the watchdog when both occur in the same cycle.
  - DRAIN: M_bubble is held at 1. When W_stat is exceptional, go to HALTED and latch cpu_stat=W_stat. The watchdog also applies in DRAIN.
  - HALTED: F_stall=D_stall=W_stall=1, D_bubble=0, E_bubble=M_bubble=1, set_cc=0, halted=1. State and counters are frozen until rst.
- Counters (saturate at all-ones, never wrap, increment only outside HALTED):
  - cycle_cnt: +1 every cycle.
  - retired_cnt: +1 when W_stat == SAOK and W_icode ≠ INOP.
  - lu_cnt: +1 on lu. mispred_cnt: +1 on mis. ret_cnt: +1 on ret & !lu.
- Latency: all stall/bubble outputs are combinational (zero cycles). halted, cpu_stat and timeout are registered and rise one edge after the triggering W_stat is observed.
- rst asserted mid-run, including in HALTED, returns the block to the reset state on the next edge.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants IHALT..IPOPQ;
  - stat codes SAOK=1, SADR=2, SINS=3, SHLT=4;
  - RESP=4, RNONE=15;
  - the FSM state enum {RUN, DRAIN, HALTED}.
- This package also replaces the per-file defines used by the processor top.
- One combinational sub-module, y86_hazard_detect, computes lu/ret/mis/exc and the raw stall/bubble terms.
- y86_pipe_ctrl holds the FSM, HALTED override and counters.

Test Plan:
- Load/use: E_icode=MRMOVQ, E_dstM=3, d_srcA=3 for 1 cycle -> F_stall=D_stall=E_bubble=1, D_bubble=0; lu_cnt=1.
- Ret: D_icode=IRET, then E, then M across 3 cycles -> F_stall=1 and D_bubble=1 each cycle; ret_cnt=3.
- Mispredict with ret in D: E_icode=JXX, e_Cnd=0, D_icode=IRET -> D_bubble=E_bubble=F_stall=1, D_stall=0; mispred_cnt=1, ret_cnt=1.
- Halt drain: m_stat=SHLT, then W_stat=SHLT next cycle -> DRAIN with M_bubble=1 and set_cc=0 for E_icode=OPQ; then halted=1, cpu_stat=4; counters frozen over 10 further cycles.
- Watchdog: MAX_CYCLES=20, no exceptions -> halted=1, timeout=1, cpu_stat=1, cycle_cnt=20.
- Reset mid-HALTED: assert rst for 1 cycle -> halted=0, counters 0, D/E/M_bubble=1 during rst; with CNT_W=4, 20 retiring cycles -> retired_cnt=15 (saturated).
